// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// The owner holds its grant for up to MAX_BURST writes, then the grant rotates. A full FIFO stalls the owner without rotating.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATAWIDTH = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
   input  logic                           fifo_full,
   output logic [NUM_REQ-1:0]             ack,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [$clog2(NUM_REQ)-1:0]     gnt_id,
   output logic                           busy,
   output logic                           fifo_wr,
   output logic [DATAWIDTH-1:0]           fifo_din
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   burst_q, burst_d;

   logic [IW-1:0]   next_owner;
   logic [IW-1:0]   scan_start;
   logic [IW:0]     pos;
   logic            sel_vld;
   logic [IW-1:0]   sel_idx;
   logic            release_now;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
      end
   end

   assign busy     = (state_q == GRANT);
   assign gnt      = busy ? (NUM_REQ'(1) << owner_q) : '0;
   assign gnt_id   = busy ? owner_q : '0;
   assign fifo_wr  = busy & req[owner_q] & ~fifo_full & ~reset;
   assign ack      = fifo_wr ? (NUM_REQ'(1) << owner_q) : '0;
   assign fifo_din = busy ? req_data[owner_q*DATAWIDTH +: DATAWIDTH] : '0;

   assign next_owner = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

   // Releasing scans from owner+1, so the old owner is seen last and only wins when alone.
   assign scan_start = busy ? next_owner : rr_ptr_q;

   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      pos     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, scan_start} + (IW+1)'(k);
         if (pos >= (IW+1)'(NUM_REQ))
            pos = pos - (IW+1)'(NUM_REQ);
         if (req[pos[IW-1:0]]) begin
            sel_vld = 1'b1;
            sel_idx = pos[IW-1:0];
         end
      end
   end

   assign release_now = ~req[owner_q] | (fifo_wr & (burst_q == CW'(MAX_BURST - 1)));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      case (state_q)
         IDLE: begin
            if (sel_vld) begin
               state_d = GRANT;
               owner_d = sel_idx;
               burst_d = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               rr_ptr_d = next_owner;
               burst_d  = '0;
               if (sel_vld)
                  owner_d = sel_idx;
               else
                  state_d = IDLE;
            end else if (fifo_wr) begin
               burst_d = burst_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer models feed directed word lists; each expected write
// (cycle, owner, data) is queued and a negedge monitor pops and compares on every fifo_wr.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic        fifo_full;
   logic [3:0]  ack;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
   logic        fifo_wr;
   logic [7:0]  fifo_din;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;
   int t0   = 0;

   logic [3:0] ack_s = 4'b0;
   logic [7:0] pdat [4][8];
   int         phd [4];
   int         pn  [4];

   typedef struct {
      int         rel;
      int         id;
      logic [7:0] dat;
   } exp_t;

   exp_t sbq[$];
   exp_t me;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATAWIDTH(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_data  (req_data),
      .fifo_full (fifo_full),
      .ack       (ack),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .fifo_wr   (fifo_wr),
      .fifo_din  (fifo_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) ack_s <= ack;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc - t0);
      end
   endtask

   // Monitor: invariants every cycle, scoreboard pop on every write.
   always @(negedge clk) begin
      chk("ack_without_wr", {31'b0, (ack != 4'b0) && !fifo_wr}, 32'd0);
      chk("wr_while_full",  {31'b0, fifo_wr && fifo_full}, 32'd0);
      if (fifo_wr) begin
         chk("wr_expected", {31'b0, sbq.size() != 0}, 32'd1);
         if (sbq.size() != 0) begin
            me = sbq.pop_front();
            chk("wr_cycle",  cyc - t0,              me.rel);
            chk("wr_gnt_id", {30'b0, gnt_id},       me.id);
            chk("wr_ack",    {28'b0, ack},          32'd1 << me.id);
            chk("wr_gnt",    {28'b0, gnt},          32'd1 << me.id);
            chk("wr_din",    {24'b0, fifo_din},     {24'b0, me.dat});
         end
      end
   end

   task automatic drive();
      for (int p = 0; p < 4; p++) begin
         req[p] = (phd[p] < pn[p]);
         if (phd[p] < pn[p])
            req_data[p*8 +: 8] = pdat[p][phd[p]];
         else
            req_data[p*8 +: 8] = 8'h00;
      end
   endtask

   // Producers advance to their next word after an acked edge.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++)
         if (ack_s[p] && phd[p] < pn[p]) phd[p]++;
      drive();
   endtask

   task automatic load(input int p, input int base, input int n);
      for (int k = 0; k < n; k++) pdat[p][k] = 8'(base + k);
      phd[p] = 0;
      pn[p]  = n;
   endtask

   task automatic ex(input int rel, input int id, input int dat);
      exp_t e;
      e.rel = rel;
      e.id  = id;
      e.dat = 8'(dat);
      sbq.push_back(e);
   endtask

   task automatic end_test(input string nm);
      @(negedge clk);
      chk({nm, "_drained"}, sbq.size(), 32'd0);
      chk({nm, "_busy"},    {31'b0, busy}, 32'd0);
      chk({nm, "_gnt"},     {28'b0, gnt},  32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      fifo_full = 1'b0;
      for (int p = 0; p < 4; p++) begin
         phd[p] = 0;
         pn[p]  = 0;
      end

      // T1: reset held two edges with all four requesting
      load(0, 'h10, 4); load(1, 'h20, 2); load(2, 'h30, 1); load(3, 'h40, 1);
      drive();
      @(negedge clk);
      chk("rst_gnt",    {28'b0, gnt},      32'd0);
      chk("rst_gnt_id", {30'b0, gnt_id},   32'd0);
      chk("rst_busy",   {31'b0, busy},     32'd0);
      chk("rst_wr",     {31'b0, fifo_wr},  32'd0);
      chk("rst_ack",    {28'b0, ack},      32'd0);
      chk("rst_din",    {24'b0, fifo_din}, 32'd0);
      tick();
      reset = 1'b0;
      t0 = cyc;
      ex(1, 0, 'h10); ex(2, 0, 'h11); ex(3, 0, 'h12); ex(4, 0, 'h13);
      ex(5, 1, 'h20); ex(6, 1, 'h21); ex(8, 2, 'h30); ex(10, 3, 'h40);
      for (int r = 1; r <= 12; r++) tick();
      end_test("t1");

      // T2: lone producer 2 with six words, re-granted after a full burst
      tick();
      load(2, 'h30, 6); drive(); t0 = cyc;
      for (int k = 0; k < 6; k++) ex(1 + k, 2, 'h30 + k);
      for (int r = 1; r <= 8; r++) tick();
      end_test("t2");

      // T3: producers 0 and 3 alternate after a fresh reset
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      load(0, 'h50, 8); load(3, 'h60, 8); drive(); t0 = cyc;
      for (int k = 0; k < 4; k++) begin
         ex(1 + k,  0, 'h50 + k);
         ex(5 + k,  3, 'h60 + k);
         ex(9 + k,  0, 'h54 + k);
         ex(13 + k, 3, 'h64 + k);
      end
      sbq.sort() with (item.rel);
      for (int r = 1; r <= 18; r++) tick();
      end_test("t3");

      // T4: FIFO full for three cycles mid-burst on producer 1
      tick();
      load(1, 'h70, 4); drive(); t0 = cyc;
      ex(1, 1, 'h70); ex(2, 1, 'h71); ex(6, 1, 'h72); ex(7, 1, 'h73);
      for (int r = 1; r <= 9; r++) begin
         tick();
         fifo_full = (r >= 3 && r <= 5);
         if (r >= 3 && r <= 5) begin
            @(negedge clk);
            chk("full_gnt_held", {28'b0, gnt},     32'h2);
            chk("full_no_wr",    {31'b0, fifo_wr}, 32'd0);
         end
      end
      end_test("t4");

      // T5: producer 0 drops after one word while 2 and 3 wait
      tick();
      load(0, 'h80, 1); drive(); t0 = cyc;
      ex(1, 0, 'h80);
      ex(3, 2, 'h90); ex(4, 2, 'h91); ex(5, 2, 'h92); ex(6, 2, 'h93);
      ex(7, 3, 'hA0); ex(9, 2, 'h94);
      for (int r = 1; r <= 11; r++) begin
         tick();
         if (r == 1) begin
            load(2, 'h90, 5); load(3, 'hA0, 1); drive();
         end
         if (r == 2) begin
            @(negedge clk);
            chk("drop_no_ack", {28'b0, ack},     32'd0);
            chk("drop_no_wr",  {31'b0, fifo_wr}, 32'd0);
            chk("drop_gnt",    {28'b0, gnt},     32'h1);
         end
      end
      end_test("t5");

      // T6: one-cycle reset two words into producer 1's burst
      tick();
      load(1, 'hB0, 4); drive(); t0 = cyc;
      ex(1, 1, 'hB0); ex(2, 1, 'hB1); ex(5, 1, 'hB2); ex(6, 1, 'hB3); ex(8, 3, 'hC0);
      for (int r = 1; r <= 10; r++) begin
         tick();
         if (r == 3) begin
            reset = 1'b1;
            load(3, 'hC0, 1); drive();
            @(negedge clk);
            chk("rstpulse_no_wr",  {31'b0, fifo_wr}, 32'd0);
            chk("rstpulse_no_ack", {28'b0, ack},     32'd0);
         end
         if (r == 4) begin
            reset = 1'b0;
            @(negedge clk);
            chk("rstpulse_gnt",    {28'b0, gnt},    32'd0);
            chk("rstpulse_busy",   {31'b0, busy},   32'd0);
            chk("rstpulse_gnt_id", {30'b0, gnt_id}, 32'd0);
         end
      end
      end_test("t6");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
